addsub_arbiter: RTL
===================

// Module: addsub_arbiter
// PURPOSE
//  Shares one 16-bit saturating add/subtract datapath between two requesters,
//  for example PC/branch-target computation and the ALU/LS address path.
//  Arbitrates round-robin, performs one operation per cycle and registers each
//  result into a one-entry output slot per requester.
//  Valid/ready handshakes are used on both the request and response sides.
// PARAMETERS
//  WIDTH      16  operand/result width; only 16 is supported
//  RR_INIT    1   reset value of last_grant, so requester 0 wins the first tie
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  r0_valid   in   1      requester 0 has an operation
//  r0_ready   out  1      requester 0 operation accepted this cycle
//  r0_a       in   16     operand A
//  r0_b       in   16     operand B
//  r0_sub     in   1      1: A-B, 0: A+B
//  o0_valid   out  1      requester 0 result slot full
//  o0_ready   in   1      requester 0 consumes result
//  o0_sum     out  16     saturated result
//  o0_ovf     out  1      result was saturated
//  r1_*/o1_*  same set for requester 1
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at posedge):
//    - oN_valid=0, oN_sum=0, oN_ovf=0, last_grant=RR_INIT.
//    - Any in-flight or unconsumed result is discarded.
//  - Slot free: freeN = ~oN_valid | oN_ready, so a drain and a refill may
//    occur in the same cycle.
//  - Eligible: eligN = rN_valid & freeN.
//  - Grant (combinational):
//    - Only one eligible requester: it is granted.
//    - Both eligible: grant = ~last_grant.
//    - Neither eligible: no grant.
//  - rN_ready = grantN. It may depend on rN_valid. The requester must hold its
//    operands stable while rN_valid=1 && rN_ready=0.
//  - On accept (rN_valid & rN_ready at posedge t):
//    - oN_sum/oN_ovf load at t, so oN_valid=1 from cycle t+1 (latency 1).
//    - last_grant <= N.
//  - Slot hold: oN_valid, oN_sum and oN_ovf are stable until oN_ready.
//    - oN_ready with no new accept: oN_valid <= 0.
//    - oN_ready with a new accept: the new result loads and oN_valid stays 1.
//  - Arithmetic: raw = A + (sub ? ~B : B) + sub, mod 2^16, two's complement.
//    - Signed overflow: opA[15]==opB'[15] && raw[15]!=opA[15],
//      where opB' = sub ? ~B : B.
//    - Positive overflow (opA[15]=0) gives 16'h7FFF; negative gives 16'h8000.
//    - ovf=1 whenever saturation occurred, else sum=raw and ovf=0.
//  - No other state. At most one operation per cycle; a grant never goes to a
//    requester whose slot is full and not draining.
// STRUCTURE
//  - Shared package addsub_pkg: SAT_POS=16'h7FFF, SAT_NEG=16'h8000,
//    REQ0=1'b0, REQ1=1'b1.
//  - One sub-module, sat_addsub16 (combinational):
//    a, b, sub -> sum, ovf. It is built from 4-bit CLA slices.
//  - Arbiter, operand mux and output slots live in addsub_arbiter.
// TESTING
//  1. Reset held for 2 cycles -> o0/o1 valid=0, sum=0, ovf=0; first tie
//     grants requester 0.
//  2. r0: 16'h0001 + 16'h0002 -> o0_sum=16'h0003, ovf=0, o0_valid the next
//     cycle.
//  3. r1: 16'h7FFF + 16'h0001 -> 16'h7FFF, ovf=1.
//     r1: 16'h8000 - 16'h0001 (sub=1) -> 16'h8000, ovf=1.
//  4. r0 and r1 both valid for 4 cycles with oN_ready=1 -> grants alternate
//     0,1,0,1 and each result appears one cycle after its grant.
//  5. o0_ready=0 with o0 full -> r0_ready=0, r1 takes every grant, and o0_sum
//     is held. Raising o0_ready drains and refills o0 in the same cycle.
//  6. rst asserted the cycle after an accept -> o0_valid=0 and no result
//     emerges; normal operation resumes after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants for the saturating add/subtract arbiter and its datapath.
package addsub_pkg;
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;
    localparam logic        REQ0    = 1'b0;
    localparam logic        REQ1    = 1'b1;
endpackage

// File: rtl/sat_addsub16.sv
// Combinational 16-bit saturating add/subtract built from four 4-bit CLA slices.
module sat_addsub16
    import addsub_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovf
);
    logic [15:0] bx;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] raw;
    logic [3:0]  cs;

    // Subtraction is A + ~B + 1, with the +1 entering as the first slice carry.
    assign bx    = sub ? ~b : b;
    assign g     = a & bx;
    assign p     = a ^ bx;
    assign cs[0] = sub;

    for (genvar s = 0; s < 4; s++) begin : g_slice
        logic [3:0] sg;
        logic [3:0] sp;
        logic [3:0] c;

        assign sg   = g[4*s +: 4];
        assign sp   = p[4*s +: 4];
        assign c[0] = cs[s];
        assign c[1] = sg[0] | (sp[0] & c[0]);
        assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
        assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                    | (sp[2] & sp[1] & sp[0] & c[0]);
        assign raw[4*s +: 4] = sp ^ c;

        if (s < 3) begin : g_cout
            assign cs[s+1] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                           | (sp[3] & sp[2] & sp[1] & sg[0])
                           | (sp[3] & sp[2] & sp[1] & sp[0] & c[0]);
        end
    end

    assign ovf = (a[15] == bx[15]) && (raw[15] != a[15]);
    assign sum = ovf ? (a[15] ? SAT_NEG : SAT_POS) : raw;
endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one saturating add/sub datapath; round-robin grant,
// one operation per cycle, one-entry registered result slot per requester.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int   WIDTH   = 16,
    parameter logic RR_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_sub,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic [WIDTH-1:0] o0_sum,
    output logic             o0_ovf,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_sub,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [WIDTH-1:0] o1_sum,
    output logic             o1_ovf
);
    logic             last_grant;
    logic             elig0, elig1;
    logic             grant0, grant1;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_sub;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;

    // A slot that is draining this cycle can accept a new result at once.
    assign elig0 = r0_valid & (~o0_valid | o0_ready);
    assign elig1 = r1_valid & (~o1_valid | o1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = (last_grant == REQ1);
            grant1 = (last_grant == REQ0);
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    assign op_a   = grant1 ? r1_a   : r0_a;
    assign op_b   = grant1 ? r1_b   : r0_b;
    assign op_sub = grant1 ? r1_sub : r0_sub;

    sat_addsub16 u_alu (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .sum (res_sum),
        .ovf (res_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o0_valid   <= 1'b0;
            o0_sum     <= '0;
            o0_ovf     <= 1'b0;
            o1_valid   <= 1'b0;
            o1_sum     <= '0;
            o1_ovf     <= 1'b0;
            last_grant <= RR_INIT;
        end else begin
            if (grant0) begin
                o0_valid <= 1'b1;
                o0_sum   <= res_sum;
                o0_ovf   <= res_ovf;
            end else if (o0_ready) begin
                o0_valid <= 1'b0;
            end
            if (grant1) begin
                o1_valid <= 1'b1;
                o1_sum   <= res_sum;
                o1_ovf   <= res_ovf;
            end else if (o1_ready) begin
                o1_valid <= 1'b0;
            end
            if (grant0 | grant1)
                last_grant <= grant1 ? REQ1 : REQ0;
        end
    end
endmodule
